// File: rtl/tug_playfield.sv
// tug_playfield
//   Input side of the tug-of-war game. Turns the two raw player keys into
//   clean single-cycle press pulses and moves a one-hot "rope" light along an
//   LED bar. When the winner block raises lock, the rope freezes and no
//   pulses are passed on.
//
// Ports:
//   clock      system clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset (0 = reset)
//   LeftRaw    raw left key, asynchronous, 1 = pressed
//   RightRaw   raw right key, asynchronous, 1 = pressed
//   lock       game-over freeze from the winner block
//   LEDR       one-hot rope position (bit NUM_LIGHTS-1 = leftmost light)
//   LeftLEDR   leftmost light
//   RightLEDR  rightmost light
//   LeftKEY    one-cycle left press pulse
//   RightKEY   one-cycle right press pulse

module tug_playfield #(
  parameter int NUM_LIGHTS = 9,
  parameter int CENTER     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  LeftRaw,
  input  logic                  RightRaw,
  input  logic                  lock,
  output logic [NUM_LIGHTS-1:0] LEDR,
  output logic                  LeftLEDR,
  output logic                  RightLEDR,
  output logic                  LeftKEY,
  output logic                  RightKEY
);

  localparam logic [NUM_LIGHTS-1:0] CenterOneHot =
    {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << CENTER;

  logic leftSync1, leftSync2, leftPrev;
  logic rightSync1, rightSync2, rightPrev;
  logic leftPulse, rightPulse;
  logic [NUM_LIGHTS-1:0] ropePos;

  // Two-flop synchronizers followed by a history flop for each key. All of
  // them reset to 1 so that a key already held down while reset is released
  // looks like "still pressed" and never produces a rising-edge pulse. These
  // flops keep running while lock is high, so a key held across the end of
  // lock is also seen as an old press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leftSync1  <= 1'b1;
      leftSync2  <= 1'b1;
      leftPrev   <= 1'b1;
      rightSync1 <= 1'b1;
      rightSync2 <= 1'b1;
      rightPrev  <= 1'b1;
    end else begin
      leftSync1  <= LeftRaw;
      leftSync2  <= leftSync1;
      leftPrev   <= leftSync2;
      rightSync1 <= RightRaw;
      rightSync2 <= rightSync1;
      rightPrev  <= rightSync2;
    end
  end

  // Rising-edge detect built only from flop outputs, so the pulses are
  // glitch-free. Simultaneous presses cancel each other, and lock suppresses
  // both outputs.
  always_comb begin
    leftPulse  = leftSync2 & ~leftPrev;
    rightPulse = rightSync2 & ~rightPrev;
    LeftKEY    = leftPulse & ~rightPulse & ~lock;
    RightKEY   = rightPulse & ~leftPulse & ~lock;
  end

  // Rope position. A press moves the lit bit one place toward that player
  // and holds at the end light instead of wrapping, so the position stays
  // one-hot. The move lands on the edge that ends the pulse cycle, which
  // means the end flags still show the pre-move position during the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ropePos <= CenterOneHot;
    end else if (LeftKEY && !ropePos[NUM_LIGHTS-1]) begin
      ropePos <= {ropePos[NUM_LIGHTS-2:0], 1'b0};
    end else if (RightKEY && !ropePos[0]) begin
      ropePos <= {1'b0, ropePos[NUM_LIGHTS-1:1]};
    end
  end

  assign LEDR      = ropePos;
  assign LeftLEDR  = ropePos[NUM_LIGHTS-1];
  assign RightLEDR = ropePos[0];

endmodule

// File: tb/tb_tug_playfield.sv
// tb_tug_playfield
//   Directed bench for tug_playfield. The stimulus side pushes each press it
//   expects to produce a pulse onto a scoreboard queue (key, pulse cycle,
//   rope before and after). A separate monitor watches the pulse outputs on
//   every falling edge, pops and compares, and flags any pulse that nobody
//   expected. Static state (reset value, end positions) is checked directly.

module tb_tug_playfield;

  localparam logic [8:0] Center = 9'b000010000;

  logic       clock;
  logic       reset;
  logic       LeftRaw;
  logic       RightRaw;
  logic       lock;
  logic [8:0] LEDR;
  logic       LeftLEDR;
  logic       RightLEDR;
  logic       LeftKEY;
  logic       RightKEY;

  typedef struct {
    bit         isLeft;
    int         cyc;
    logic [8:0] pre;
    logic [8:0] post;
  } expT;

  expT        sbQueue[$];
  int         cyc = 0;
  int         vectors = 0;
  int         fails = 0;
  bit         pendingPost = 0;
  logic [8:0] postExp;

  tug_playfield #(.NUM_LIGHTS(9), .CENTER(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .LeftRaw   (LeftRaw),
    .RightRaw  (RightRaw),
    .lock      (lock),
    .LEDR      (LEDR),
    .LeftLEDR  (LeftLEDR),
    .RightLEDR (RightLEDR),
    .LeftKEY   (LeftKEY),
    .RightKEY  (RightKEY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter used to check pulse latency
  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: on each falling edge, finish any pending post-move check, then
  // match a visible pulse against the head of the scoreboard.
  always @(negedge clock) begin
    expT e;
    if (!reset) begin
      pendingPost = 0;
    end else begin
      if (pendingPost) begin
        checkOutput("post-move LEDR", {23'b0, LEDR}, {23'b0, postExp});
        pendingPost = 0;
      end
      if (LeftKEY || RightKEY) begin
        if (sbQueue.size() == 0) begin
          vectors++;
          fails++;
          $display("[TB] FAIL unexpected pulse: got L=%0b R=%0b at cycle %0d, expected none",
                   LeftKEY, RightKEY, cyc);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("pulse LeftKEY", {31'b0, LeftKEY}, {31'b0, e.isLeft});
          checkOutput("pulse RightKEY", {31'b0, RightKEY}, {31'b0, !e.isLeft});
          checkOutput("pulse cycle", cyc, e.cyc);
          checkOutput("pulse LEDR pre-move", {23'b0, LEDR}, {23'b0, e.pre});
          checkOutput("pulse LeftLEDR", {31'b0, LeftLEDR}, {31'b0, e.pre[8]});
          checkOutput("pulse RightLEDR", {31'b0, RightLEDR}, {31'b0, e.pre[0]});
          postExp     = e.post;
          pendingPost = 1;
        end
      end
    end
  end

  // One key press: raise the raw key on a falling edge, hold it, release,
  // then leave enough idle cycles for the synchronizer to settle back to 0.
  // The pulse is expected two rising edges after the key goes high.
  task automatic applyStimulus(input bit isLeft, input bit expPulse,
                               input logic [8:0] pre, input logic [8:0] post,
                               input int hold);
    expT e;
    @(negedge clock);
    if (expPulse) begin
      e.isLeft = isLeft;
      e.cyc    = cyc + 2;
      e.pre    = pre;
      e.post   = post;
      sbQueue.push_back(e);
    end
    if (isLeft) LeftRaw = 1'b1;
    else        RightRaw = 1'b1;
    repeat (hold) @(negedge clock);
    LeftRaw  = 1'b0;
    RightRaw = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    LeftRaw  = 1'b0;
    RightRaw = 1'b0;
    lock     = 1'b0;
    #1 reset = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset LEDR", {23'b0, LEDR}, {23'b0, Center});
    checkOutput("reset LeftKEY", {31'b0, LeftKEY}, 32'd0);
    checkOutput("reset RightKEY", {31'b0, RightKEY}, 32'd0);
    checkOutput("reset LeftLEDR", {31'b0, LeftLEDR}, 32'd0);
    checkOutput("reset RightLEDR", {31'b0, RightLEDR}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Two right presses, then reset asynchronously mid-operation
    applyStimulus(0, 1, 9'b000010000, 9'b000001000, 3);
    applyStimulus(0, 1, 9'b000001000, 9'b000000100, 3);
    checkOutput("rope before async reset", {23'b0, LEDR}, {23'b0, 9'b000000100});
    @(negedge clock);
    #2 reset = 1'b0;
    #1 checkOutput("async reset LEDR", {23'b0, LEDR}, {23'b0, Center});
    LeftRaw = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    LeftRaw = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("key held through reset LEDR", {23'b0, LEDR}, {23'b0, Center});

    // Single press latency with a long hold, then walk to the left end
    applyStimulus(1, 1, 9'b000010000, 9'b000100000, 10);
    checkOutput("single press LEDR", {23'b0, LEDR}, {23'b0, 9'b000100000});
    applyStimulus(1, 1, 9'b000100000, 9'b001000000, 3);
    applyStimulus(1, 1, 9'b001000000, 9'b010000000, 3);
    applyStimulus(1, 1, 9'b010000000, 9'b100000000, 3);
    checkOutput("left end LEDR", {23'b0, LEDR}, {23'b0, 9'b100000000});
    checkOutput("left end LeftLEDR", {31'b0, LeftLEDR}, 32'd1);
    applyStimulus(1, 1, 9'b100000000, 9'b100000000, 3);
    checkOutput("left end held LEDR", {23'b0, LEDR}, {23'b0, 9'b100000000});

    // Right end saturation from reset
    doReset();
    applyStimulus(0, 1, 9'b000010000, 9'b000001000, 3);
    applyStimulus(0, 1, 9'b000001000, 9'b000000100, 3);
    applyStimulus(0, 1, 9'b000000100, 9'b000000010, 3);
    applyStimulus(0, 1, 9'b000000010, 9'b000000001, 3);
    checkOutput("right end LEDR", {23'b0, LEDR}, {23'b0, 9'b000000001});
    checkOutput("right end RightLEDR", {31'b0, RightLEDR}, 32'd1);
    applyStimulus(0, 1, 9'b000000001, 9'b000000001, 3);
    applyStimulus(0, 1, 9'b000000001, 9'b000000001, 3);
    checkOutput("right end held LEDR", {23'b0, LEDR}, {23'b0, 9'b000000001});

    // Simultaneous press cancels
    doReset();
    @(negedge clock);
    LeftRaw  = 1'b1;
    RightRaw = 1'b1;
    repeat (5) @(negedge clock);
    LeftRaw  = 1'b0;
    RightRaw = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("simultaneous LEDR", {23'b0, LEDR}, {23'b0, Center});

    // Lock freezes the rope; a key held across unlock does not fire
    @(negedge clock);
    lock = 1'b1;
    applyStimulus(1, 0, Center, Center, 3);
    applyStimulus(1, 0, Center, Center, 3);
    applyStimulus(1, 0, Center, Center, 3);
    checkOutput("locked LEDR", {23'b0, LEDR}, {23'b0, Center});
    LeftRaw = 1'b1;
    repeat (5) @(negedge clock);
    lock = 1'b0;
    repeat (5) @(negedge clock);
    LeftRaw = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("unlock held key LEDR", {23'b0, LEDR}, {23'b0, Center});
    applyStimulus(1, 1, 9'b000010000, 9'b000100000, 3);
    checkOutput("after unlock LEDR", {23'b0, LEDR}, {23'b0, 9'b000100000});

    repeat (3) @(negedge clock);
    checkOutput("scoreboard drained", sbQueue.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/tug_playfield.md
Name: tug_playfield

Overview:
- Input-side partner of the tug-of-war winner latch. Conditions the two raw player keys into single-cycle press pulses and moves a one-hot "rope" light across an LED bar.
- Drives the end-light flags and press pulses that the winner block consumes: LeftLEDR/RightLEDR plus LeftKEY/RightKEY.
- Freezes when the winner block signals the game is over.

Parameters:
- NUM_LIGHTS, 9, LED bar length. Must be ≥3. Bit NUM_LIGHTS-1 is the leftmost light; bit 0 is the rightmost.
- CENTER, 4, index lit after reset. Must satisfy 0 < CENTER < NUM_LIGHTS-1.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- LeftRaw  in  1  raw left player key, asynchronous, 1 = pressed.
- RightRaw  in  1  raw right player key, asynchronous, 1 = pressed.
- lock  in  1  game-over freeze, driven high by the winner block once a winner is latched.
- LEDR  out  NUM_LIGHTS  one-hot rope position.
- LeftLEDR  out  1  equals LEDR[NUM_LIGHTS-1].
- RightLEDR  out  1  equals LEDR[0].
- LeftKEY  out  1  one-cycle left press pulse.
- RightKEY  out  1  one-cycle right press pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - LEDR = one-hot at CENTER.
  - All synchronizer and edge-history flops = 1, so a key held through reset produces no pulse.
  - LeftKEY = RightKEY = 0.
- Per key:
  - Two-flop synchronizer s1→s2, then history flop p.
  - pulse = s2 & ~p, combinational from flops only, so it is glitch-free.
- Latency:
  - Raw rise sampled at edge E.
  - Pulse is high for exactly the cycle between E+1 and E+2.
  - Position changes at E+2.
- A key held high gives one pulse only. Release gives no pulse. A new press needs s2 to have returned to 0.
- Gating:
  - LeftKEY = left pulse & ~right pulse & ~lock.
  - RightKEY = right pulse & ~left pulse & ~lock.
  - Simultaneous pulses: both outputs 0 and no move.
- Move rule, evaluated at the clock edge ending a pulse cycle:
  - LeftKEY and position < NUM_LIGHTS-1: shift one toward the left.
  - LeftKEY and position = NUM_LIGHTS-1: hold (no wrap-around).
  - RightKEY follows the mirror-image rule, holding at position 0.
- End-light timing: during a pulse cycle, LeftLEDR/RightLEDR show the pre-move position.
  - The press that moves the rope onto an end light does not coincide with that end flag high.
  - The winner block therefore fires only on a further press while the rope sits at the end.
- lock=1:
  - LEDR frozen and both pulse outputs 0.
  - Synchronizer and history flops keep running, so a key held across lock deassertion does not fire.
- reset asserted mid-pulse: pulse drops immediately and LEDR returns to CENTER.
- LEDR is always exactly one-hot; never zero, never multi-hot.

Test Plan:
- Reset behaviour: assert reset=0 mid-operation with LEDR=9'b000000100 → LEDR=9'b000010000 immediately, without waiting for a clock edge. Release with LeftRaw held at 1 → no LeftKEY pulse ever, LEDR stays at CENTER.
- Single press latency: LeftRaw 0→1 before edge E and held 10 cycles → LeftKEY=1 only between E+1 and E+2; LEDR=9'b000100000 after E+2; no further change.
- Walk to end and win handshake:
  - After 4 left presses, LEDR=9'b100000000 and LeftLEDR=1, but LeftKEY was 0 in the cycle LeftLEDR rose.
  - A 5th press → LeftKEY=1 with LeftLEDR=1 and LEDR unchanged (held at the end).
- Right end saturation: 6 right presses from reset → LEDR=9'b000000001 after the 4th. The 5th and 6th pulse RightKEY with RightLEDR=1 and LEDR unchanged.
- Simultaneous press: LeftRaw and RightRaw rise in the same cycle → LeftKEY=RightKEY=0 throughout; LEDR stays 9'b000010000.
- Lock: with lock=1, 3 left presses → no pulses, LEDR frozen. Drop lock while LeftRaw is held → no pulse. Release and press again → one LeftKEY pulse and the rope moves.
